// File: rtl/gng_uart_tx.sv
// Serialises 16-bit noise samples as two 8N1 UART frames (low byte first) on txd, via a small sample FIFO.
// Latency: a sample written into an empty FIFO at edge N drives the start bit at edge N+1; one sample = 20 bit periods.
// Backpressure: none upstream; a write into a full FIFO is dropped and sets the sticky overflow flag.
// Ports: clk/reset (async active-high); valid_in/data_in sample stream; cfg_enable gates new samples;
//        cfg_baud_div = clk cycles per bit (values below 2 act as 2); txd idle-high serial output;
//        busy = serialiser active; overflow = sticky drop flag; fifo_level = queued sample count.
module gng_uart_tx #(
   parameter int FIFO_DEPTH = 8,
   parameter int DATA_W     = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          valid_in,
   input  logic [DATA_W-1:0]             data_in,
   input  logic                          cfg_enable,
   input  logic [15:0]                   cfg_baud_div,
   output logic                          txd,
   output logic                          busy,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int LVL_W = AW + 1;
   localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   // ---------------- sample FIFO ----------------
   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic              fifo_empty, fifo_full, fifo_push, fifo_pop;
   logic [DATA_W-1:0] fifo_head;

   assign fifo_empty = (fifo_level == '0);
   assign fifo_full  = (fifo_level == FULL_LVL);
   assign fifo_head  = mem[rd_ptr];
   // Fullness is judged before any pop in the same cycle, so a write at full is always dropped.
   assign fifo_push  = valid_in && !fifo_full;

   always_ff @(posedge clk) begin
      if (fifo_push) begin
         mem[wr_ptr] <= data_in;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
         overflow   <= 1'b0;
      end else begin
         if (fifo_push) wr_ptr <= wr_ptr + AW'(1);
         if (fifo_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({fifo_push, fifo_pop})
            2'b10:   fifo_level <= fifo_level + LVL_W'(1);
            2'b01:   fifo_level <= fifo_level - LVL_W'(1);
            default: fifo_level <= fifo_level;
         endcase
         if (valid_in && fifo_full) overflow <= 1'b1;
      end
   end

   // ---------------- serialiser ----------------
   state_t            state;
   logic [15:0]       baud_cnt;
   logic [2:0]        bit_idx;
   logic              byte_sel;
   logic [DATA_W-1:0] hold;
   logic [15:0]       bit_load;
   logic [7:0]        cur_byte;
   logic              bit_done;

   // Bit period is clamped to 2 cycles minimum; the counter is loaded with P-1 at each bit start,
   // so cfg_baud_div changes only take effect on the following bit.
   assign bit_load = ((cfg_baud_div < 16'd2) ? 16'd2 : cfg_baud_div) - 16'd1;
   assign bit_done = (baud_cnt == 16'd0);
   assign cur_byte = byte_sel ? hold[15:8] : hold[7:0];

   // A new sample may start from IDLE, or straight out of the second byte's stop bit with no gap.
   assign fifo_pop = cfg_enable && !fifo_empty &&
                     ((state == S_IDLE) || ((state == S_STOP) && bit_done && byte_sel));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_IDLE;
         txd      <= 1'b1;
         busy     <= 1'b0;
         baud_cnt <= 16'd0;
         bit_idx  <= 3'd0;
         byte_sel <= 1'b0;
         hold     <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (fifo_pop) begin
                  hold     <= fifo_head;
                  byte_sel <= 1'b0;
                  txd      <= 1'b0;
                  busy     <= 1'b1;
                  baud_cnt <= bit_load;
                  state    <= S_START;
               end
            end
            S_START: begin
               if (bit_done) begin
                  bit_idx  <= 3'd0;
                  txd      <= cur_byte[0];
                  baud_cnt <= bit_load;
                  state    <= S_DATA;
               end else begin
                  baud_cnt <= baud_cnt - 16'd1;
               end
            end
            S_DATA: begin
               if (bit_done) begin
                  baud_cnt <= bit_load;
                  if (bit_idx == 3'd7) begin
                     txd   <= 1'b1;
                     state <= S_STOP;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     txd     <= cur_byte[bit_idx + 3'd1];
                  end
               end else begin
                  baud_cnt <= baud_cnt - 16'd1;
               end
            end
            S_STOP: begin
               if (bit_done) begin
                  if (!byte_sel) begin
                     byte_sel <= 1'b1;
                     txd      <= 1'b0;
                     baud_cnt <= bit_load;
                     state    <= S_START;
                  end else if (fifo_pop) begin
                     hold     <= fifo_head;
                     byte_sel <= 1'b0;
                     txd      <= 1'b0;
                     baud_cnt <= bit_load;
                     state    <= S_START;
                  end else begin
                     txd   <= 1'b1;
                     busy  <= 1'b0;
                     state <= S_IDLE;
                  end
               end else begin
                  baud_cnt <= baud_cnt - 16'd1;
               end
            end
            default: begin
               state <= S_IDLE;
               txd   <= 1'b1;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/gng_uart_tx.md
Name: gng_uart_tx

Overview:
- Downstream consumer of the Gaussian noise generator output stream (valid_out / data_out, 16-bit samples).
- Buffers samples in a small FIFO and serialises each one as two 8N1 UART frames on a single txd line, low byte first.
- Gives the board a way to stream noise samples to a host. Baud timing is a runtime config port, in the same style as the UART bridge's cfg_baud_16x.

Parameters:
- FIFO_DEPTH, 8, sample FIFO depth; power of two, at least 2.
- DATA_W, 16, sample width; fixed at 16 (two bytes per sample).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous active-high reset
- valid_in  input  1  sample strobe from the generator (valid_out)
- data_in  input  16  sample from the generator (data_out)
- cfg_enable  input  1  1 = serialiser may start new samples
- cfg_baud_div  input  16  clk cycles per UART bit
- txd  output  1  UART serial out; idle high
- busy  output  1  serialiser not in IDLE
- overflow  output  1  sticky: a sample was dropped
- fifo_level  output  $clog2(FIFO_DEPTH)+1  number of entries in the FIFO

Behaviour:
- Reset is asynchronous, active-high. During and after reset: txd=1, busy=0, overflow=0, fifo_level=0, state IDLE, FIFO empty, baud counter 0.
- Reset asserted mid-frame: txd returns to 1 immediately, without waiting for a clock edge. The in-flight sample is lost.
- FIFO write: at an edge where valid_in=1 and the FIFO is not full, data_in is pushed.
- Fullness is evaluated before any same-cycle pop. A write arriving while full is dropped even if a pop occurs in the same cycle, and overflow is set to 1.
- overflow clears only on reset.
- A write and a pop in the same cycle with the FIFO not full are both performed, and fifo_level is unchanged.
- Effective bit period P = max(cfg_baud_div, 2) clk cycles. cfg_baud_div is sampled when each bit starts; changing it mid-bit takes effect at the next bit.
- FSM states: IDLE, START, DATA, STOP.
- IDLE: when cfg_enable=1 and the FIFO is not empty, at the next edge:
  - pop the head sample into a 16-bit holding register;
  - set byte_sel=0;
  - drive txd=0;
  - go to START.
- Latency: a sample pushed into an empty FIFO at edge N produces the start-bit falling edge on txd at edge N+1.
- START: hold txd=0 for P cycles, then go to DATA with bit index 0.
- DATA: drive the selected byte LSB first (byte_sel=0 is data[7:0], byte_sel=1 is data[15:8]). Each bit lasts P cycles. After bit 7, go to STOP with txd=1.
- STOP: hold txd=1 for P cycles, then:
  - if byte_sel=0: set byte_sel=1, drive txd=0, go to START (second byte follows back-to-back, no idle gap);
  - if byte_sel=1: apply the IDLE rule in the same edge. If a new sample is eligible it starts immediately with no gap; otherwise go to IDLE with txd=1.
- Frame timing: one sample = 20 bit periods = 20*P cycles.
- cfg_enable deasserted mid-sample: both bytes of the current sample still complete. No new sample starts until cfg_enable=1.
- busy=1 in START, DATA and STOP; 0 in IDLE.
- txd is registered, so there are no combinational glitches.

Test Plan:
- Reset check: assert reset mid-frame -> txd=1, busy=0, overflow=0, fifo_level=0 with no clock edge; after release, txd stays 1.
- Single sample: cfg_baud_div=4, cfg_enable=1, push 0xA55A at edge N.
  - txd per 4-cycle bit from edge N+1: 0, 0,1,0,1,1,0,1,0, 1, 0, 1,0,1,0,0,1,0,1, 1.
  - busy high exactly 80 cycles.
- Divider clamp: cfg_baud_div=0, push 0x00FF -> every bit lasts 2 cycles; busy high 40 cycles.
- Overflow: cfg_baud_div=4, push 10 samples on consecutive edges starting from an empty FIFO.
  - After the 9th write: fifo_level=8.
  - 10th sample dropped; overflow=1 and stays 1.
  - Exactly 9 samples appear on txd, back-to-back with no idle gap, in push order.
- Simultaneous push/pop at full: FIFO full with the serialiser finishing STOP, and valid_in=1 on the pop edge -> the new sample is dropped, overflow=1, fifo_level=7 afterwards.
- Enable gating: deassert cfg_enable during the first byte of sample A, with B queued -> A's 20 bits complete; txd then idles high and B is held. Re-enable -> B's start bit follows 1 cycle later.
